// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM-side definitions: generation encoding, SKP scheduler state, default intervals.
package pcie_ltssm_pkg;

   localparam logic GEN_LOW  = 1'b0;   // 8b/10b rates, 4-symbol SKP
   localparam logic GEN_HIGH = 1'b1;   // 128b/130b rates, 16-symbol SKP

   localparam int SKP_INT_LOW_DEF  = 1180;
   localparam int SKP_INT_HIGH_DEF = 5920;   // 370 blocks x 16 symbols
   localparam int MAX_PENDING_DEF  = 4;
   localparam int CNT_WIDTH_DEF    = 13;
   localparam int SKP_TIMEOUT_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ARMED      = 2'd1,
      SKP_ACTIVE = 2'd2
   } skp_state_e;

endpackage

// File: rtl/skp_interval_counter.sv
// Gen-selected modulo symbol counter; pulses hit_o on the last symbol of each interval.
module skp_interval_counter
   import pcie_ltssm_pkg::*;
#(
   parameter int INT_LOW   = SKP_INT_LOW_DEF,
   parameter int INT_HIGH  = SKP_INT_HIGH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic gen_i,
   input  logic adv_i,    // one symbol time elapsed
   input  logic clr_i,    // flush; wins over advance and suppresses the hit
   output logic hit_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, last;

   assign last  = (gen_i == GEN_HIGH) ? CNT_WIDTH'(INT_HIGH - 1) : CNT_WIDTH'(INT_LOW - 1);
   assign hit_o = adv_i && !clr_i && (cnt_q == last);

   // Next count: clear, wrap on the interval's last symbol, or step
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (adv_i)
         cnt_d = hit_o ? '0 : cnt_q + CNT_WIDTH'(1);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/skp_scheduler.sv
// SKP ordered-set scheduler: queues interval expiries and releases each SKP on an OS/data boundary.
module skp_scheduler
   import pcie_ltssm_pkg::*;
#(
   parameter int SKP_INT_LOW  = SKP_INT_LOW_DEF,
   parameter int SKP_INT_HIGH = SKP_INT_HIGH_DEF,
   parameter int MAX_PENDING  = MAX_PENDING_DEF,
   parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
   parameter int SKP_TIMEOUT  = SKP_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       gen,
   input  logic       enable_LTSSM,
   input  logic       tx_eidle,
   input  logic       sched_clr,
   input  logic       os_creator_done,
   input  logic       data_boundary,
   input  logic       skp_done,
   output logic       skp_enable,
   output logic [2:0] skp_pending,
   output logic       skp_overflow,
   output logic       skp_timeout_err
);

   localparam int         TMO_W    = $clog2(SKP_TIMEOUT + 1);
   localparam logic [2:0] PEND_MAX = 3'(MAX_PENDING);

   skp_state_e        state_q, state_d;
   logic [2:0]        pend_q, pend_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              en_q, en_d, ovf_q, ovf_d, err_q, err_d;
   logic              flush, hit, done_act, tmo_fire, dec;

   assign flush = tx_eidle || sched_clr;

   skp_interval_counter #(
      .INT_LOW   (SKP_INT_LOW),
      .INT_HIGH  (SKP_INT_HIGH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .gen_i (gen),
      .adv_i (enable_LTSSM && !tx_eidle),
      .clr_i (flush),
      .hit_o (hit)
   );

   assign done_act = (state_q == SKP_ACTIVE) && skp_done;
   // skp_done on the same cycle wins over the timeout
   assign tmo_fire = (state_q == SKP_ACTIVE) && !skp_done && enable_LTSSM &&
                     (tmo_q == TMO_W'(SKP_TIMEOUT - 1));
   assign dec      = done_act || tmo_fire;

   // Queue update, FSM next state and timeout counter; flush overrides everything
   always_comb begin
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      state_d = state_q;
      tmo_d   = '0;

      // A hit and a completion in the same cycle cancel out
      if (hit && !dec) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + 3'd1;
      end else if (!hit && dec && pend_q != 3'd0) begin
         pend_d = pend_q - 3'd1;
      end

      case (state_q)
         IDLE:
            if (pend_q != 3'd0 || hit) state_d = ARMED;
         ARMED:
            if ((os_creator_done || data_boundary) && enable_LTSSM) state_d = SKP_ACTIVE;
         SKP_ACTIVE: begin
            if (skp_done) begin
               // Back-to-back SKP when more are queued; timeout restarts either way
               if (pend_d == 3'd0) state_d = IDLE;
            end else if (tmo_fire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (enable_LTSSM) begin
               tmo_d = tmo_q + TMO_W'(1);
            end else begin
               tmo_d = tmo_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         pend_d  = '0;
         tmo_d   = '0;
         ovf_d   = ovf_q;
         err_d   = err_q;
      end

      en_d = (state_d == SKP_ACTIVE);
   end

   // State, queue, flags and registered skp_enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         tmo_q   <= '0;
         en_q    <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         tmo_q   <= tmo_d;
         en_q    <= en_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign skp_enable      = en_q;
   assign skp_pending     = pend_q;
   assign skp_overflow    = ovf_q;
   assign skp_timeout_err = err_q;

endmodule

// File: tb/tb_skp_scheduler.sv
// Directed bench for skp_scheduler with short intervals (20 / 48 symbols).
module tb_skp_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       gen = 1'b0, enable_LTSSM = 1'b0, tx_eidle = 1'b0, sched_clr = 1'b0;
   logic       os_creator_done = 1'b0, data_boundary = 1'b0, skp_done = 1'b0;
   logic       skp_enable, skp_overflow, skp_timeout_err;
   logic [2:0] skp_pending;

   int errors = 0;
   int checks = 0;

   skp_scheduler #(
      .SKP_INT_LOW  (20),
      .SKP_INT_HIGH (48),
      .MAX_PENDING  (4),
      .CNT_WIDTH    (13),
      .SKP_TIMEOUT  (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .gen             (gen),
      .enable_LTSSM    (enable_LTSSM),
      .tx_eidle        (tx_eidle),
      .sched_clr       (sched_clr),
      .os_creator_done (os_creator_done),
      .data_boundary   (data_boundary),
      .skp_done        (skp_done),
      .skp_enable      (skp_enable),
      .skp_pending     (skp_pending),
      .skp_overflow    (skp_overflow),
      .skp_timeout_err (skp_timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance n clock edges; outputs are sampled 1 time unit after each edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sched_clear();
      enable_LTSSM = 1'b0;
      sched_clr    = 1'b1;
      tick(1);
      sched_clr    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b exp 0", skp_enable); end
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL rst_pending: got %0d exp 0", skp_pending); end
      checks++; if (skp_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b exp 0", skp_overflow); end
      checks++; if (skp_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", skp_timeout_err); end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      gen = 1'b0;
      enable_LTSSM = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         os_creator_done = (k % 4 == 0);
         tick(1);
         if (k == 16) begin
            checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t1_idle_boundary: got %b exp 0", skp_enable); end
         end
         if (k == 19) begin
            checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t1_pend_pre: got %0d exp 0", skp_pending); end
         end
      end
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t1_pend_hit: got %0d exp 1", skp_pending); end
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t1_armed: got %b exp 0", skp_enable); end
      os_creator_done = 1'b0;
      tick(3);
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t1_wait_bnd: got %b exp 0", skp_enable); end
      os_creator_done = 1'b1;
      tick(1);
      os_creator_done = 1'b0;
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t1_rise: got %b exp 1", skp_enable); end
      tick(3);
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t1_hold: got %b exp 1", skp_enable); end
      skp_done = 1'b1;
      tick(1);
      skp_done = 1'b0;
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t1_fall: got %b exp 0", skp_enable); end
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t1_pend_end: got %0d exp 0", skp_pending); end
      sched_clear();
   endtask

   task automatic test_hit_and_done();
      sched_clear();
      gen = 1'b0;
      enable_LTSSM = 1'b1;
      tick(20);
      os_creator_done = 1'b1;
      tick(1);
      os_creator_done = 1'b0;
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t3_active: got %b exp 1", skp_enable); end
      tick(18);
      skp_done = 1'b1;
      tick(1);
      skp_done = 1'b0;
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t3_pend_same: got %0d exp 1", skp_pending); end
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t3_b2b: got %b exp 1", skp_enable); end
      checks++; if (skp_overflow !== 1'b0) begin errors++; $display("FAIL t3_no_ovf: got %b exp 0", skp_overflow); end
      tick(2);
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t3_b2b_hold: got %b exp 1", skp_enable); end
      skp_done = 1'b1;
      tick(1);
      skp_done = 1'b0;
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t3_fall: got %b exp 0", skp_enable); end
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t3_pend_end: got %0d exp 0", skp_pending); end
      sched_clear();
   endtask

   task automatic test_eidle_flush();
      sched_clear();
      gen = 1'b0;
      enable_LTSSM = 1'b1;
      tick(20);
      os_creator_done = 1'b1;
      tick(1);
      os_creator_done = 1'b0;
      tick(19);
      checks++; if (skp_pending !== 3'd2) begin errors++; $display("FAIL t4_pend2: got %0d exp 2", skp_pending); end
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t4_active: got %b exp 1", skp_enable); end
      tx_eidle = 1'b1;
      tick(1);
      tx_eidle = 1'b0;
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t4_flush_en: got %b exp 0", skp_enable); end
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t4_flush_pend: got %0d exp 0", skp_pending); end
      tick(19);
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t4_cnt_pre: got %0d exp 0", skp_pending); end
      tick(1);
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t4_cnt_hit: got %0d exp 1", skp_pending); end
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t4_idle: got %b exp 0", skp_enable); end
      sched_clear();
   endtask

   task automatic test_timeout();
      sched_clear();
      gen = 1'b0;
      enable_LTSSM = 1'b1;
      tick(20);
      os_creator_done = 1'b1;
      tick(1);
      os_creator_done = 1'b0;
      tick(31);
      checks++; if (skp_timeout_err !== 1'b0) begin errors++; $display("FAIL t5_err_pre: got %b exp 0", skp_timeout_err); end
      checks++; if (skp_enable !== 1'b1) begin errors++; $display("FAIL t5_en_pre: got %b exp 1", skp_enable); end
      checks++; if (skp_pending !== 3'd2) begin errors++; $display("FAIL t5_pend_pre: got %0d exp 2", skp_pending); end
      tick(1);
      checks++; if (skp_timeout_err !== 1'b1) begin errors++; $display("FAIL t5_err: got %b exp 1", skp_timeout_err); end
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t5_en_drop: got %b exp 0", skp_enable); end
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t5_pend_dec: got %0d exp 1", skp_pending); end
      sched_clear();
      checks++; if (skp_timeout_err !== 1'b1) begin errors++; $display("FAIL t5_sticky: got %b exp 1", skp_timeout_err); end
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t5_clr_pend: got %0d exp 0", skp_pending); end
   endtask

   task automatic test_overflow();
      gen = 1'b1;
      sched_clear();
      enable_LTSSM = 1'b1;
      tick(47);
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t2_pend47: got %0d exp 0", skp_pending); end
      tick(1);
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t2_pend48: got %0d exp 1", skp_pending); end
      tick(191);
      checks++; if (skp_pending !== 3'd4) begin errors++; $display("FAIL t2_pend_full: got %0d exp 4", skp_pending); end
      checks++; if (skp_overflow !== 1'b0) begin errors++; $display("FAIL t2_ovf_pre: got %b exp 0", skp_overflow); end
      tick(1);
      checks++; if (skp_overflow !== 1'b1) begin errors++; $display("FAIL t2_ovf: got %b exp 1", skp_overflow); end
      checks++; if (skp_pending !== 3'd4) begin errors++; $display("FAIL t2_pend_sat: got %0d exp 4", skp_pending); end
      tick(10);
      checks++; if (skp_pending !== 3'd4) begin errors++; $display("FAIL t2_pend_250: got %0d exp 4", skp_pending); end
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t2_no_bnd: got %b exp 0", skp_enable); end
      gen = 1'b0;
      sched_clear();
      checks++; if (skp_overflow !== 1'b1) begin errors++; $display("FAIL t2_sticky: got %b exp 1", skp_overflow); end
   endtask

   task automatic test_reset_armed();
      sched_clear();
      gen = 1'b0;
      enable_LTSSM = 1'b1;
      tick(20);
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t6_armed_pend: got %0d exp 1", skp_pending); end
      #2 rst = 1'b0;
      #1;
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t6_async_pend: got %0d exp 0", skp_pending); end
      checks++; if (skp_enable !== 1'b0) begin errors++; $display("FAIL t6_async_en: got %b exp 0", skp_enable); end
      checks++; if (skp_overflow !== 1'b0) begin errors++; $display("FAIL t6_async_ovf: got %b exp 0", skp_overflow); end
      checks++; if (skp_timeout_err !== 1'b0) begin errors++; $display("FAIL t6_async_err: got %b exp 0", skp_timeout_err); end
      @(posedge clk); #1;
      rst = 1'b1;
      tick(19);
      checks++; if (skp_pending !== 3'd0) begin errors++; $display("FAIL t6_pend19: got %0d exp 0", skp_pending); end
      tick(1);
      checks++; if (skp_pending !== 3'd1) begin errors++; $display("FAIL t6_pend20: got %0d exp 1", skp_pending); end
      enable_LTSSM = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hit_and_done();
      test_eidle_flush();
      test_timeout();
      test_overflow();
      test_reset_armed();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
